dea_frame_sequencer: RTL and testbench

Controls the XOR-cipher path between the UART receiver and UART sender. It captures one framed request from the UART byte stream: data length, data bytes, key length, key bytes. It then XORs each data byte with the repeating key, one byte per cycle, and streams the ciphertext back through the UART sender. It holds plaintext and ciphertext buffers and provides a read port so the LED display logic can page through characters.

---
 rtl/dea_frame_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_dea_frame_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dea_frame_sequencer.sv
// dea_frame_sequencer: captures one framed request (length, data, key length,
// key) from the UART receiver, XORs the data with the repeating key one byte
// per cycle, and streams the ciphertext back through the UART sender.
// Optional feature macro: DEA_LEN_HEADER_EN -- when defined, the frame length is
// sent as a header byte ahead of the ciphertext.
module dea_frame_sequencer #(
  parameter int MAX_DATA = 100,
  parameter int MAX_KEY  = 4
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Ready,
  output logic       Rx_Ack,
  output logic [7:0] Tx_Data,
  output logic       Tx_Send,
  input  logic       Tx_Busy,
  input  logic [7:0] view_idx,
  output logic [7:0] view_plain,
  output logic [7:0] view_cipher,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int DAW = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;
  localparam int KAW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;
  localparam logic [7:0] MAX_DATA_B = 8'(MAX_DATA);
  localparam logic [7:0] MAX_KEY_B  = 8'(MAX_KEY);

  typedef enum logic [2:0] {
    S_LEN, S_DATA, S_KLEN, S_KEY, S_ENC, S_TXHDR, S_TXDATA, S_ERR
  } state_t;

  // Per-byte sender handshake: wait idle, hold request until busy, wait done.
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} txph_t;

  state_t     state_q, state_d;
  txph_t      txph_q, txph_d;
  logic [7:0] len_q, len_d;
  logic [7:0] klen_q, klen_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] i_q, i_d;
  logic [7:0] k_q, k_d;
  logic       rx_ack_q, rx_ack_d;
  logic       tx_send_q, tx_send_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       done_q, done_d;

  logic       rx_accept;
  logic       data_we, key_we, res_we;
  logic [7:0] tx_byte;

  // Buffers are deliberately left out of reset; the display sees stale bytes.
  logic [7:0] data_mem   [MAX_DATA];
  logic [7:0] key_mem    [MAX_KEY];
  logic [7:0] result_mem [MAX_DATA];

  assign rx_accept   = Rx_Ready & ~rx_ack_q;
  assign Rx_Ack      = rx_ack_q;
  assign Tx_Send     = tx_send_q;
  assign Tx_Data     = tx_data_q;
  assign done        = done_q;
  assign err         = (state_q == S_ERR);
  assign busy        = (state_q != S_LEN) && (state_q != S_ERR);
  assign view_plain  = (view_idx < MAX_DATA_B) ? data_mem[view_idx[DAW-1:0]] : 8'h00;
  assign view_cipher = (view_idx < MAX_DATA_B) ? result_mem[view_idx[DAW-1:0]] : 8'h00;
  assign tx_byte     = (state_q == S_TXHDR) ? len_q : result_mem[i_q[DAW-1:0]];

  // Control registers: state, counters and handshake outputs.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state_q   <= S_LEN;
      txph_q    <= TX_IDLE;
      len_q     <= '0;
      klen_q    <= '0;
      cnt_q     <= '0;
      i_q       <= '0;
      k_q       <= '0;
      rx_ack_q  <= 1'b0;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      txph_q    <= txph_d;
      len_q     <= len_d;
      klen_q    <= klen_d;
      cnt_q     <= cnt_d;
      i_q       <= i_d;
      k_q       <= k_d;
      rx_ack_q  <= rx_ack_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  // Buffer writes: captured data/key bytes and one ciphertext byte per S_ENC cycle.
  always_ff @(posedge Clk_100M) begin
    if (data_we) data_mem[cnt_q[DAW-1:0]] <= Rx_Data;
    if (key_we)  key_mem[cnt_q[KAW-1:0]]  <= Rx_Data;
    if (res_we)  result_mem[i_q[DAW-1:0]] <= data_mem[i_q[DAW-1:0]] ^ key_mem[k_q[KAW-1:0]];
  end

  // Next-state logic: frame parsing, encryption walk and sender handshake.
  always_comb begin
    state_d   = state_q;
    txph_d    = txph_q;
    len_d     = len_q;
    klen_d    = klen_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    k_d       = k_q;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    data_we   = 1'b0;
    key_we    = 1'b0;
    res_we    = 1'b0;

    // The receiver is always serviced, even when the byte is thrown away.
    rx_ack_d = rx_ack_q;
    if (rx_accept)      rx_ack_d = 1'b1;
    else if (!Rx_Ready) rx_ack_d = 1'b0;

    case (state_q)
      S_LEN: begin
        if (rx_accept && (Rx_Data != 8'h00)) begin
          if (Rx_Data > MAX_DATA_B) begin
            state_d = S_ERR;
          end else begin
            len_d   = Rx_Data;
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_accept) begin
          data_we = 1'b1;
          if (cnt_q == len_q - 8'd1) begin
            cnt_d   = '0;
            state_d = S_KLEN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_KLEN: begin
        if (rx_accept) begin
          if ((Rx_Data == 8'h00) || (Rx_Data > MAX_KEY_B)) begin
            state_d = S_ERR;
          end else begin
            klen_d  = Rx_Data;
            cnt_d   = '0;
            state_d = S_KEY;
          end
        end
      end
      S_KEY: begin
        if (rx_accept) begin
          key_we = 1'b1;
          if (cnt_q == klen_q - 8'd1) begin
            cnt_d   = '0;
            i_d     = '0;
            k_d     = '0;
            state_d = S_ENC;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_ENC: begin
        res_we = 1'b1;
        // Key index wraps by compare rather than modulo.
        k_d = (k_q == klen_q - 8'd1) ? 8'd0 : k_q + 8'd1;
        if (i_q == len_q - 8'd1) begin
          i_d    = '0;
          txph_d = TX_IDLE;
`ifdef DEA_LEN_HEADER_EN
          state_d = S_TXHDR;
`else
          state_d = S_TXDATA;
`endif
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      S_TXHDR, S_TXDATA: begin
        case (txph_q)
          TX_IDLE: begin
            if (!Tx_Busy) begin
              tx_data_d = tx_byte;
              tx_send_d = 1'b1;
              txph_d    = TX_SEND;
            end
          end
          TX_SEND: begin
            if (Tx_Busy) begin
              tx_send_d = 1'b0;
              txph_d    = TX_WAIT;
            end
          end
          default: begin
            if (!Tx_Busy) begin
              txph_d = TX_IDLE;
              if (state_q == S_TXHDR) begin
                i_d     = '0;
                state_d = S_TXDATA;
              end else if (i_q == len_q - 8'd1) begin
                i_d     = '0;
                done_d  = 1'b1;
                state_d = S_LEN;
              end else begin
                i_d = i_q + 8'd1;
              end
            end
          end
        endcase
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_LEN;
      end
    endcase
  end

endmodule

// File: tb/tb_dea_frame_sequencer.sv
// Self-checking bench for dea_frame_sequencer: random and directed frames
// against a frame-level reference model (ciphertext = data ^ key[i % klen]).
module tb_dea_frame_sequencer;

  localparam int MAX_DATA = 100;
  localparam int MAX_KEY  = 4;
`ifdef DEA_LEN_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Rx_Data;
  logic       Rx_Ready;
  logic       Rx_Ack;
  logic [7:0] Tx_Data;
  logic       Tx_Send;
  logic       Tx_Busy;
  logic [7:0] view_idx;
  logic [7:0] view_plain;
  logic [7:0] view_cipher;
  logic       busy;
  logic       done;
  logic       err;

  dea_frame_sequencer #(.MAX_DATA(MAX_DATA), .MAX_KEY(MAX_KEY)) dut (
    .Clk_100M(clk), .Reset(Reset), .Rx_Data(Rx_Data), .Rx_Ready(Rx_Ready),
    .Rx_Ack(Rx_Ack), .Tx_Data(Tx_Data), .Tx_Send(Tx_Send), .Tx_Busy(Tx_Busy),
    .view_idx(view_idx), .view_plain(view_plain), .view_cipher(view_cipher),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] expq [$];
  logic [7:0] txlog [$];
  int txcyc [$];
  int done_cnt = 0;
  int hold_max = 2;
  int busy_min = 1;
  int busy_max = 4;

  logic [7:0] fd [256];
  logic [7:0] fk [256];
  int fl, fkl;

  function automatic void chk(input bit ok, input string nm, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endfunction

  function automatic int txat(input int idx);
    if (idx < txlog.size()) return int'(txlog[idx]);
    return -1;
  endfunction

  // UART sender model and ciphertext scoreboard.
  initial begin
    int sph, hold, bc;
    logic [7:0] cap, e;
    sph = 0; hold = 0; bc = 0; cap = 8'h00;
    Tx_Busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (sph)
        0: begin
          if (Tx_Send === 1'b1) begin
            cap = Tx_Data;
            txlog.push_back(cap);
            txcyc.push_back(cyc);
            if (expq.size() == 0) chk(1'b0, "tx_extra", cap, 0);
            else begin
              e = expq.pop_front();
              chk(cap == e, "tx_byte", cap, e);
            end
            hold = $urandom_range(0, hold_max);
            sph = 1;
          end
        end
        1: begin
          chk(Tx_Send == 1'b1, "send_hold", Tx_Send, 1);
          chk(Tx_Data == cap, "data_hold", Tx_Data, cap);
          chk(busy == 1'b1, "busy_tx", busy, 1);
          if (hold == 0) begin
            Tx_Busy = 1'b1;
            bc = $urandom_range(busy_min, busy_max);
            sph = 2;
          end else hold--;
        end
        default: begin
          chk(Tx_Send == 1'b0, "send_drop", Tx_Send, 0);
          chk(Tx_Data == cap, "data_stall", Tx_Data, cap);
          if (bc <= 1) begin
            Tx_Busy = 1'b0;
            sph = 0;
          end else bc--;
        end
      endcase
    end
  end

  // done must be a single-cycle pulse and only after every expected byte went out.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_cnt++;
        chk(prev == 1'b0, "done_width", 2, 1);
        chk(expq.size() == 0, "done_early", expq.size(), 0);
      end
      prev = (done === 1'b1);
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acyc);
    int h;
    Rx_Data = b;
    Rx_Ready = 1'b1;
    @(posedge clk); #1;
    chk(Rx_Ack == 1'b1, "ack_rise", Rx_Ack, 1);
    acyc = cyc;
    h = $urandom_range(0, 2);
    for (int j = 0; j < h; j++) begin
      @(posedge clk); #1;
      chk(Rx_Ack == 1'b1, "ack_hold", Rx_Ack, 1);
    end
    Rx_Ready = 1'b0;
    @(posedge clk); #1;
    chk(Rx_Ack == 1'b0, "ack_fall", Rx_Ack, 0);
    Rx_Data = 8'($urandom);
    h = $urandom_range(0, 2);
    for (int j = 0; j < h; j++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    chk(Rx_Ack == 1'b0, "rst_ack", Rx_Ack, 0);
    chk(Tx_Send == 1'b0, "rst_send", Tx_Send, 0);
    chk(Tx_Data == 8'h00, "rst_txdata", Tx_Data, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(err == 1'b0, "rst_err", err, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
  endtask

  // Sends the frame held in fd/fl/fk/fkl and checks everything it must produce.
  task automatic run_frame();
    int a, kexit, t0, dc0, t;
    logic [7:0] c;
    for (int j = 0; j < HDR; j++) expq.push_back(8'(fl));
    for (int j = 0; j < fl; j++) expq.push_back(fd[j] ^ fk[j % fkl]);
    t0 = txlog.size();
    dc0 = done_cnt;
    send_byte(8'(fl), a);
    for (int j = 0; j < fl; j++) send_byte(fd[j], a);
    send_byte(8'(fkl), a);
    kexit = a;
    for (int j = 0; j < fkl; j++) begin
      send_byte(fk[j], a);
      kexit = a;
    end
    t = 0;
    while (done_cnt == dc0 && t < 6000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk(done_cnt == dc0 + 1, "done_count", done_cnt - dc0, 1);
    chk(expq.size() == 0, "tx_missing", expq.size(), 0);
    chk(txlog.size() - t0 == fl + HDR, "tx_count", txlog.size() - t0, fl + HDR);
    if (txlog.size() > t0)
      chk(txcyc[t0] - kexit == fl + 1, "enc_latency", txcyc[t0] - kexit, fl + 1);
    else
      chk(1'b0, "enc_latency", -1, fl + 1);
    expq.delete();
    chk(busy == 1'b0, "busy_idle", busy, 0);
    chk(err == 1'b0, "err_clear", err, 0);
    for (int j = 0; j < fl; j++) begin
      view_idx = 8'(j);
      #1;
      c = fd[j] ^ fk[j % fkl];
      chk(view_plain == fd[j], "view_plain", view_plain, fd[j]);
      chk(view_cipher == c, "view_cipher", view_cipher, c);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, t0;
    logic [7:0] wrap [5];
    logic [7:0] abc [4];
    Reset = 1'b1; Rx_Data = 8'h00; Rx_Ready = 1'b0; view_idx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Reference frame "ABC" with key {1,2}.
    abc[0] = 8'h03; abc[1] = 8'h40; abc[2] = 8'h40; abc[3] = 8'h42;
    fl = 3; fd[0] = 8'h41; fd[1] = 8'h42; fd[2] = 8'h43;
    fkl = 2; fk[0] = 8'h01; fk[1] = 8'h02;
    t0 = txlog.size();
    run_frame();
    for (int j = 0; j < 3 + HDR; j++)
      chk(txat(t0 + j) == int'(abc[j + 1 - HDR]), "abc_tx", txat(t0 + j), abc[j + 1 - HDR]);
    view_idx = 8'd2; #1;
    chk(view_cipher == 8'h42, "abc_view_cipher", view_cipher, 8'h42);
    view_idx = 8'd0; #1;
    chk(view_plain == 8'h41, "abc_view_plain", view_plain, 8'h41);

    // Key wrap over five zero data bytes.
    wrap[0] = 8'h10; wrap[1] = 8'h20; wrap[2] = 8'h30; wrap[3] = 8'h10; wrap[4] = 8'h20;
    fl = 5; fkl = 3; fk[0] = 8'h10; fk[1] = 8'h20; fk[2] = 8'h30;
    for (int j = 0; j < 5; j++) fd[j] = 8'h00;
    run_frame();
    for (int j = 0; j < 5; j++) begin
      view_idx = 8'(j); #1;
      chk(view_cipher == wrap[j], "wrap_cipher", view_cipher, wrap[j]);
    end

    // Zero length byte is ignored.
    send_byte(8'h00, a);
    chk(busy == 1'b0, "zero_len_idle", busy, 0);
    fl = 1; fd[0] = 8'h7F; fkl = 1; fk[0] = 8'hFF;
    run_frame();
    chk(txat(txlog.size() - 1) == 8'h80, "zero_len_tx", txat(txlog.size() - 1), 8'h80);

    // Oversize length: error, bytes still acked, nothing sent, reset recovers.
    t0 = txlog.size();
    send_byte(8'h65, a);
    chk(err == 1'b1, "err_len", err, 1);
    chk(busy == 1'b0, "err_busy", busy, 0);
    for (int j = 0; j < 3; j++) send_byte(8'($urandom), a);
    repeat (20) @(posedge clk);
    #1;
    chk(err == 1'b1, "err_sticky", err, 1);
    chk(txlog.size() == t0, "err_no_tx", txlog.size() - t0, 0);
    do_reset();
    fl = 3; fd[0] = 8'h41; fd[1] = 8'h42; fd[2] = 8'h43;
    fkl = 2; fk[0] = 8'h01; fk[1] = 8'h02;
    run_frame();

    // Key length out of range, both ends.
    send_byte(8'h01, a); send_byte(8'h55, a); send_byte(8'(MAX_KEY + 1), a);
    chk(err == 1'b1, "err_klen_big", err, 1);
    do_reset();
    send_byte(8'h01, a); send_byte(8'h55, a); send_byte(8'h00, a);
    chk(err == 1'b1, "err_klen_zero", err, 1);
    do_reset();

    // Largest legal frame and key.
    fl = MAX_DATA; fkl = MAX_KEY;
    for (int j = 0; j < fl; j++) fd[j] = 8'($urandom);
    for (int j = 0; j < fkl; j++) fk[j] = 8'($urandom);
    hold_max = 0; busy_min = 1; busy_max = 1;
    run_frame();

    // Reset mid data, then a new frame with a long sender stall.
    send_byte(8'h04, a); send_byte(8'hAA, a); send_byte(8'hBB, a);
    chk(busy == 1'b1, "mid_busy", busy, 1);
    do_reset();
    hold_max = 4; busy_min = 50; busy_max = 50;
    fl = 2; fd[0] = 8'h5A; fd[1] = 8'hC3; fkl = 1; fk[0] = 8'h0F;
    run_frame();

    // Randomized frames and sender timing.
    for (int n = 0; n < 10; n++) begin
      hold_max = $urandom_range(0, 3);
      busy_min = 1;
      busy_max = $urandom_range(1, 5);
      fl = $urandom_range(1, 24);
      fkl = $urandom_range(1, MAX_KEY);
      for (int j = 0; j < fl; j++) fd[j] = 8'($urandom);
      for (int j = 0; j < fkl; j++) fk[j] = 8'($urandom);
      run_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
